cand_gather: RTL and testbench
==============================

# cand_gather

Candidate gatherer that feeds the four-input comparator tree. It takes a serial stream of 19-bit candidate words and packs them into groups of four. Short groups are padded with a neutral value that can never win a minimum compare. Each group is presented as four parallel words with a valid/ready handshake. It sits between the neighbour-cost producer and the 4:1 comparator reduction; there is one comparator tree per gatherer.

## Interface

Parameters:
- W, default 19, candidate word width.
- PAD, default all-ones (19'h7FFFF), fill value for unused slots.
- SEQW, default 8, width of the group sequence counter.

Ports:
- clk, input, 1, single clock; all state is updated on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- s_valid, input, 1, candidate word present.
- s_ready, output, 1, gatherer can accept a word this cycle.
- s_data, input, W, candidate word.
- s_last, input, 1, this word closes the current group, even if the group has fewer than 4 words.
- m_valid, output, 1, packed group present.
- m_ready, input, 1, consumer takes the group this cycle.
- m_in_0 .. m_in_3, output, W each, group slots in arrival order (slot 0 = first word).
- m_count, output, 3, number of real words in the group, 1..4.
- m_seq, output, SEQW, group sequence number; increments per presented group and wraps.

## Operation

Storage:
- Assembly bank: asm[0..3], fill index idx (0..3), flag asm_full.
- Output bank: out[0..3], m_count, m_seq, m_valid.

Flow rules:
- Word accept = s_valid && s_ready.
- Transfer = asm_full && (!m_valid || m_ready).
- s_ready = !asm_full || transfer. This is a combinational path from m_ready and is intentional: it allows full throughput.

On accept:
- asm[idx] <= s_data.
- If idx==3 or s_last: asm_full <= 1, latch the group count as idx+1, idx <= 0.
- Otherwise idx <= idx+1.

On transfer:
- out[k] <= asm[k] for every k.
- m_count <= latched count.
- m_valid <= 1.
- m_seq <= m_seq+1, except for the first group after reset, which presents m_seq = 0.
- asm_full <= 0.
- Every asm slot is reset to PAD, except the slot written by a simultaneous accept.

Consume without transfer: m_valid && m_ready && !transfer -> m_valid <= 0.

Output stability:
- While m_valid && !m_ready, all m_* outputs hold stable.
- Slots beyond m_count always read PAD.

Reset (async, any time, including mid-group):
- idx=0, asm_full=0, asm[*]=PAD, out[*]=PAD.
- m_valid=0, m_count=0, m_seq=0.
- s_ready=1 once rst deasserts.
- Partial groups in flight are discarded.

Boundary conditions:
- s_last on the 4th word is identical to a plain 4th word; the group count is 4.
- s_last on the 1st word gives a 1-word group with slots 1..3 = PAD.
- Both banks full (asm_full && m_valid && !m_ready): s_ready=0, no word is lost.
- Simultaneous transfer and new accept: the new word lands in slot 0 of the freshly cleared assembly bank; other slots = PAD.
- m_seq wraps from 2^SEQW-1 to 0 with no flag.

## Timing

- Latency: group-closing word accepted at edge N -> asm_full at N -> transfer at edge N+1 (output bank free) -> m_valid high in the cycle after edge N+1.
- Best-case latency from the closing word to m_valid is 1 cycle.
- Throughput: one word per cycle sustained while m_ready=1.
- Throughput: one group per 4 cycles when all groups are full.
- Backpressure: up to 2 complete groups are buffered (assembly bank plus output bank) before s_ready deasserts.
- s_ready may drop combinationally in the same cycle m_ready drops.

## Test plan

1. Reset, m_ready=1, send 0x00010, 0x00020, 0x00030, 0x00040 on consecutive cycles (s_last on the 4th) -> one cycle after the 4th accept: m_valid=1, m_in_0..3 = 0x00010, 0x00020, 0x00030, 0x00040, m_count=4, m_seq=0.
2. Send 0x00005, 0x00006 with s_last on the 2nd -> m_in_0=0x00005, m_in_1=0x00006, m_in_2=m_in_3=0x7FFFF, m_count=2.
3. Hold m_ready=0 and stream 12 words with no s_last:
   - 8 words are accepted (groups 0 and 1); s_ready=0 from the cycle after the 8th accept.
   - Outputs hold group 0 unchanged.
   - Raising m_ready yields seq 0, 1, 2 in order with no loss or duplication.
4. Continuous stream of 40 words with m_ready=1 -> s_ready stays 1 throughout; 10 groups are presented with m_seq 0..9, one group every 4 cycles.
5. Accept 3 words, assert rst asynchronously between edges:
   - m_valid=0 immediately and all slots = PAD.
   - After release, 4 new words form a group whose contents contain none of the pre-reset words; m_seq=0.
6. With SEQW=2, send 5 full groups -> m_seq sequence 0, 1, 2, 3, 0.

Source files
------------

// File: rtl/cand_gather.sv
// Packs a serial candidate stream into groups of four for the 4:1 min-compare tree.
// Unused slots carry PAD so they can never win a minimum compare.
module cand_gather #(
  parameter int W = 19,
  parameter logic [W-1:0] PAD = {W{1'b1}},
  parameter int SEQW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_in_0,
  output logic [W-1:0]    m_in_1,
  output logic [W-1:0]    m_in_2,
  output logic [W-1:0]    m_in_3,
  output logic [2:0]      m_count,
  output logic [SEQW-1:0] m_seq
);

  logic [W-1:0] asm_q [4];
  logic [W-1:0] out_q [4];
  logic [1:0]   idx;
  logic         asm_full;
  logic [2:0]   asm_cnt;
  logic         seq_started;

  logic accept;
  logic transfer;
  logic closing;

  // s_ready looks through to m_ready so a full assembly bank can refill in the
  // same cycle it hands off, sustaining one word per cycle.
  assign transfer = asm_full && (!m_valid || m_ready);
  assign s_ready  = !asm_full || transfer;
  assign accept   = s_valid && s_ready;
  assign closing  = (idx == 2'd3) || s_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        asm_q[k] <= PAD;
        out_q[k] <= PAD;
      end
      idx         <= 2'd0;
      asm_full    <= 1'b0;
      asm_cnt     <= 3'd0;
      seq_started <= 1'b0;
      m_valid     <= 1'b0;
      m_count     <= 3'd0;
      m_seq       <= '0;
    end else begin
      // A word accepted during a transfer always targets slot 0 (idx is 0 while full).
      for (int k = 0; k < 4; k++) begin
        if (accept && (idx == 2'(k)))
          asm_q[k] <= s_data;
        else if (transfer)
          asm_q[k] <= PAD;
      end

      if (accept) begin
        if (closing) begin
          asm_cnt <= {1'b0, idx} + 3'd1;
          idx     <= 2'd0;
        end else begin
          idx     <= idx + 2'd1;
        end
      end

      if (accept && closing)
        asm_full <= 1'b1;
      else if (transfer)
        asm_full <= 1'b0;

      if (transfer) begin
        for (int k = 0; k < 4; k++)
          out_q[k] <= asm_q[k];
        m_count     <= asm_cnt;
        m_valid     <= 1'b1;
        seq_started <= 1'b1;
        m_seq       <= seq_started ? m_seq + 1'b1 : '0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_in_0 = out_q[0];
  assign m_in_1 = out_q[1];
  assign m_in_2 = out_q[2];
  assign m_in_3 = out_q[3];

endmodule

// File: tb/tb_cand_gather.sv
// Bench for cand_gather: queue-of-groups reference model, decoupled output monitor.
module tb_cand_gather;
  localparam int W = 19;
  localparam logic [W-1:0] PAD = 19'h7FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [W-1:0] s_data = '0;

  logic s_ready, m_valid;
  logic [W-1:0] m_in_0, m_in_1, m_in_2, m_in_3;
  logic [2:0] m_count;
  logic [7:0] m_seq;

  logic s_ready_b, m_valid_b;
  logic [W-1:0] mb_in_0, mb_in_1, mb_in_2, mb_in_3;
  logic [2:0] m_count_b;
  logic [1:0] m_seq_b;

  cand_gather #(.W(W), .PAD(PAD), .SEQW(8)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_in_0(m_in_0),
    .m_in_1(m_in_1), .m_in_2(m_in_2), .m_in_3(m_in_3), .m_count(m_count), .m_seq(m_seq));

  cand_gather #(.W(W), .PAD(PAD), .SEQW(2)) u_small (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready), .m_in_0(mb_in_0),
    .m_in_1(mb_in_1), .m_in_2(mb_in_2), .m_in_3(mb_in_3), .m_count(m_count_b), .m_seq(m_seq_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][W-1:0] d;
    logic [2:0]        cnt;
    logic [31:0]       seq;
  } grp_t;

  grp_t         exp_q[$];
  logic [W-1:0] cur[$];
  int           grp_no = 0;
  int           checks = 0;
  int           failures = 0;
  int           n_acc = 0;
  int           n_out = 0;
  logic         hold_prev = 1'b0;
  logic [87:0]  snap;
  logic         rand_rdy = 1'b0;
  grp_t         e;
  grp_t         g;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor and reference model: groups close on s_last or the fourth word.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev)
        chk("hold_stable", {m_valid, m_in_3, m_in_2, m_in_1, m_in_0, m_count, m_seq}, snap);
      hold_prev = m_valid && !m_ready;
      snap = {m_valid, m_in_3, m_in_2, m_in_1, m_in_0, m_count, m_seq};

      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_group actual_seq=%0d expected=none", m_seq);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          chk("grp_data", {m_in_3, m_in_2, m_in_1, m_in_0}, e.d);
          chk("grp_count", m_count, e.cnt);
          chk("grp_seq", m_seq, e.seq % 256);
          chk("small_valid", m_valid_b, 1'b1);
          chk("small_data", {mb_in_3, mb_in_2, mb_in_1, mb_in_0}, e.d);
          chk("small_count", m_count_b, e.cnt);
          chk("small_seq", m_seq_b, e.seq % 4);
        end
      end

      if (s_valid && s_ready) begin
        n_acc++;
        cur.push_back(s_data);
        if (s_last || cur.size() == 4) begin
          for (int k = 0; k < 4; k++)
            g.d[k] = (k < cur.size()) ? cur[k] : PAD;
          g.cnt = 3'(cur.size());
          g.seq = grp_no;
          exp_q.push_back(g);
          grp_no++;
          cur.delete();
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [W-1:0] d, input logic l);
    int  t;
    logic acc;
    t = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=stalled expected=accept");
        break;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    cur.delete();
    exp_q.delete();
    grp_no = 0;
    hold_prev = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_slots", {m_in_3, m_in_2, m_in_1, m_in_0}, {4{PAD}});
    chk("rst_count_seq", {m_count, m_seq}, 11'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rand_rdy = 1'b0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int t0;
    int out0;

    do_reset();

    // Full group, latency and contents
    m_ready = 1'b1;
    send(19'h00010, 1'b0);
    send(19'h00020, 1'b0);
    send(19'h00030, 1'b0);
    send(19'h00040, 1'b1);
    @(negedge clk);
    chk("lat_not_early", m_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid", m_valid, 1'b1);
    chk("t1_data", {m_in_3, m_in_2, m_in_1, m_in_0}, {19'h00040, 19'h00030, 19'h00020, 19'h00010});
    chk("t1_count_seq", {m_count, m_seq}, {3'd4, 8'd0});
    drain();

    // Short group padded
    send(19'h00005, 1'b0);
    send(19'h00006, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_pad", {m_valid, m_in_3, m_in_2, m_count}, {1'b1, PAD, PAD, 3'd2});
    drain();

    // Single-word group
    send(19'h01234, 1'b1);
    drain();

    // Backpressure: two groups buffered, then release
    do_reset();
    m_ready = 1'b0;
    base = n_acc;
    fork
      for (int i = 0; i < 12; i++) send(19'h00100 + 19'(i), 1'b0);
      begin
        repeat (20) @(negedge clk);
        chk("bp_accepted", n_acc - base, 8);
        chk("bp_s_ready", s_ready, 1'b0);
        chk("bp_head", {m_valid, m_in_0, m_seq}, {1'b1, 19'h00100, 8'd0});
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Sustained stream at full rate
    m_ready = 1'b1;
    out0 = n_out;
    t0 = $time;
    for (int i = 0; i < 40; i++) send(19'(32'h2000 + i * 3), 1'b0);
    chk("stream_cycles", ($time - t0) / 10, 40);
    drain();
    chk("stream_groups", n_out - out0, 10);

    // Async reset mid-group with a held output group
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(19'h3AAA0 + 19'(i), 1'b0);
    for (int i = 0; i < 3; i++) send(19'h3BBB0 + 19'(i), 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", m_valid, 1'b1);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(19'h00C00 + 19'(i), 1'b0);
    drain();

    // Sequence wrap on the SEQW=2 instance: 0,1,2,3,0
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(19'(32'h4000 + i), 1'b0);
    drain();

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(19'($urandom), ($urandom_range(0, 4) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
